lcd_cmd_scheduler: RTL and testbench



---
 rtl/lcd_cmd_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_lcd_cmd_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_scheduler.sv
// HD44780 text-LCD bus owner: power-on init sequence, then round-robin issue of
// two requesters' command/data bytes, each as one timed slot with an E strobe.
module lcd_cmd_scheduler #(
    parameter int PWR_CYCLES  = 70,
    parameter int CMD_CYCLES  = 31,
    parameter int LONG_CYCLES = 101,
    parameter int E_SETUP     = 5,
    parameter int E_WIDTH     = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int MAX_CYC = (LONG_CYCLES > CMD_CYCLES)
                           ? ((LONG_CYCLES > PWR_CYCLES) ? LONG_CYCLES : PWR_CYCLES)
                           : ((CMD_CYCLES > PWR_CYCLES) ? CMD_CYCLES : PWR_CYCLES);
    localparam int CNT_W = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] C_PWR_LAST  = CNT_W'(PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CMD_LAST  = CNT_W'(CMD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_E_ON      = CNT_W'(E_SETUP);
    localparam logic [CNT_W-1:0] C_E_OFF     = CNT_W'(E_SETUP + E_WIDTH);

    localparam logic [1:0] ST_PWR_WAIT  = 2'd0;
    localparam logic [1:0] ST_INIT_SLOT = 2'd1;
    localparam logic [1:0] ST_IDLE      = 2'd2;
    localparam logic [1:0] ST_ISSUE     = 2'd3;

    localparam logic [1:0] C_INIT_LAST = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_init_idx;
    logic             r_init_done;
    logic             r_busy;
    logic             r_e;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_ready0;
    logic             r_ready1;
    logic             r_prio1;
    logic             r_cap_rs;
    logic [7:0]       r_cap_data;

    logic [1:0]       w_nstate;
    logic [CNT_W-1:0] w_ncnt;
    logic [1:0]       w_nidx;
    logic             w_slot_long;
    logic             w_slot_last;
    logic             w_nrs;
    logic [7:0]       w_ndata;
    logic             w_nin_slot;
    logic             w_ne;
    logic             w_grant_ok;
    logic             w_gnt0;
    logic             w_gnt1;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0F;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    // Clear and home instructions need the long execution time on the LCD.
    assign w_slot_long = !r_rs && (r_data[7:2] == 6'd0) && (r_data != 8'h00);
    assign w_slot_last = (r_cnt == (w_slot_long ? C_LONG_LAST : C_CMD_LAST));

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt + CNT_W'(1);
        w_nidx   = r_init_idx;
        case (r_state)
            ST_PWR_WAIT: begin
                if (r_cnt == C_PWR_LAST) begin
                    w_nstate = ST_INIT_SLOT;
                    w_ncnt   = '0;
                    w_nidx   = 2'd0;
                end
            end
            ST_INIT_SLOT: begin
                if (w_slot_last) begin
                    w_ncnt = '0;
                    if (r_init_idx == C_INIT_LAST) w_nstate = ST_IDLE;
                    else                           w_nidx   = r_init_idx + 2'd1;
                end
            end
            ST_IDLE: begin
                w_ncnt = '0;
                if (r_ready0 || r_ready1) w_nstate = ST_ISSUE;
            end
            default: begin
                if (w_slot_last) begin
                    w_nstate = ST_IDLE;
                    w_ncnt   = '0;
                end
            end
        endcase
    end

    // Bus outputs are computed from the next state so the registered values
    // line up exactly with the state/counter they describe.
    always_comb begin
        w_nrs   = r_rs;
        w_ndata = r_data;
        if (w_nstate == ST_INIT_SLOT && w_ncnt == '0) begin
            w_nrs   = 1'b0;
            w_ndata = init_byte(w_nidx);
        end else if (w_nstate == ST_ISSUE && r_state == ST_IDLE) begin
            w_nrs   = r_cap_rs;
            w_ndata = r_cap_data;
        end
    end

    assign w_nin_slot = (w_nstate == ST_INIT_SLOT) || (w_nstate == ST_ISSUE);
    assign w_ne       = w_nin_slot && (w_ncnt >= C_E_ON) && (w_ncnt < C_E_OFF);

    // A grant is only made for a cycle that will itself be IDLE.
    assign w_grant_ok = (w_nstate == ST_IDLE);
    assign w_gnt0     = w_grant_ok && req0_valid && (!req1_valid || !r_prio1);
    assign w_gnt1     = w_grant_ok && req1_valid && (!req0_valid ||  r_prio1);

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PWR_WAIT;
            r_cnt       <= '0;
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_ready0    <= 1'b0;
            r_ready1    <= 1'b0;
            r_prio1     <= 1'b0;
            r_cap_rs    <= 1'b0;
            r_cap_data  <= 8'h00;
        end else begin
            r_state     <= w_nstate;
            r_cnt       <= w_ncnt;
            r_init_idx  <= w_nidx;
            r_init_done <= r_init_done || (w_nstate == ST_IDLE);
            r_busy      <= w_nin_slot;
            r_e         <= w_ne;
            r_rs        <= w_nrs;
            r_data      <= w_ndata;
            r_ready0    <= w_gnt0;
            r_ready1    <= w_gnt1;
            if (w_gnt0) begin
                r_prio1    <= 1'b1;
                r_cap_rs   <= req0_rs;
                r_cap_data <= req0_data;
            end else if (w_gnt1) begin
                r_prio1    <= 1'b0;
                r_cap_rs   <= req1_rs;
                r_cap_data <= req1_data;
            end
        end
    end

    assign req0_ready = r_ready0;
    assign req1_ready = r_ready1;
    assign init_done  = r_init_done;
    assign busy       = r_busy;
    assign LCD_E      = r_e;
    assign LCD_RS     = r_rs;
    assign LCD_RW     = 1'b0;
    assign LCD_DATA   = r_data;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler: init timeline, single/long/back-to-back
// issues, requests during init and reset in the middle of a slot.
module tb_lcd_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic       init_done, busy;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;

    int checks = 0;
    int errors = 0;

    lcd_cmd_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .init_done  (init_done),
        .busy       (busy),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_DATA   (LCD_DATA)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Follows one bus slot from its cnt=0 cycle to the first cycle after it.
    task automatic observe_slot(input logic rs, input logic [7:0] d, input int len, input string name);
        logic exp_e;
        for (int c = 0; c < len; c++) begin
            if (c != 0) tick();
            exp_e = (c >= 5) && (c < 20);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy cnt %0d got %0b want 1", name, c, busy); end
            checks++; if (LCD_E !== exp_e) begin errors++; $display("FAIL %s_lcd_e cnt %0d got %0b want %0b", name, c, LCD_E, exp_e); end
            checks++; if (LCD_RS !== rs) begin errors++; $display("FAIL %s_lcd_rs cnt %0d got %0b want %0b", name, c, LCD_RS, rs); end
            checks++; if (LCD_DATA !== d) begin errors++; $display("FAIL %s_lcd_data cnt %0d got %h want %h", name, c, LCD_DATA, d); end
            checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL %s_ready_in_slot cnt %0d got %0b%0b want 00", name, c, req0_ready, req1_ready); end
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %0b want 0", name, busy); end
        checks++; if (LCD_E !== 1'b0) begin errors++; $display("FAIL %s_lcd_e_end got %0b want 0", name, LCD_E); end
        checks++; if (LCD_DATA !== d) begin errors++; $display("FAIL %s_data_hold got %h want %h", name, LCD_DATA, d); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'hAA;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h55;
        repeat (3) tick();
        checks++; if (LCD_E !== 1'b0) begin errors++; $display("FAIL reset_lcd_e got %0b want 0", LCD_E); end
        checks++; if (LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_lcd_rs got %0b want 0", LCD_RS); end
        checks++; if (LCD_RW !== 1'b0) begin errors++; $display("FAIL reset_lcd_rw got %0b want 0", LCD_RW); end
        checks++; if (LCD_DATA !== 8'h00) begin errors++; $display("FAIL reset_lcd_data got %h want 00", LCD_DATA); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %0b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %0b want 0", req1_ready); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %0b want 0", init_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_init;
        logic [7:0] init_bytes [4];
        logic       exp_e, exp_busy, exp_done, prev_e;
        logic [7:0] exp_data;
        int         slot, off, rises, high;
        init_bytes = '{8'h38, 8'h0F, 8'h06, 8'h01};
        rises = 0; high = 0; prev_e = 1'b0;
        rst = 1'b0;
        for (int e = 1; e <= 264; e++) begin
            tick();
            if      (e < 70)  begin slot = -1; off = 0;       end
            else if (e < 101) begin slot = 0;  off = e - 70;  end
            else if (e < 132) begin slot = 1;  off = e - 101; end
            else if (e < 163) begin slot = 2;  off = e - 132; end
            else if (e < 264) begin slot = 3;  off = e - 163; end
            else              begin slot = -1; off = 0;       end
            exp_busy = (slot >= 0);
            exp_e    = exp_busy && (off >= 5) && (off < 20);
            exp_done = (e >= 264);
            exp_data = (e < 70) ? 8'h00 : (e >= 264) ? 8'h01 : init_bytes[slot];
            checks++; if (LCD_E !== exp_e) begin errors++; $display("FAIL init_lcd_e edge %0d got %0b want %0b", e, LCD_E, exp_e); end
            checks++; if (LCD_DATA !== exp_data) begin errors++; $display("FAIL init_lcd_data edge %0d got %h want %h", e, LCD_DATA, exp_data); end
            checks++; if (LCD_RS !== 1'b0) begin errors++; $display("FAIL init_lcd_rs edge %0d got %0b want 0", e, LCD_RS); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL init_busy edge %0d got %0b want %0b", e, busy, exp_busy); end
            checks++; if (init_done !== exp_done) begin errors++; $display("FAIL init_done edge %0d got %0b want %0b", e, init_done, exp_done); end
            checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL init_ready edge %0d got %0b%0b want 00", e, req0_ready, req1_ready); end
            if (LCD_E === 1'b1) high++;
            if (LCD_E === 1'b1 && prev_e === 1'b0) rises++;
            prev_e = LCD_E;
        end
        checks++; if (rises !== 4) begin errors++; $display("FAIL init_e_pulses got %0d want 4", rises); end
        checks++; if (high !== 60) begin errors++; $display("FAIL init_e_high_cycles got %0d want 60", high); end
    endtask

    task automatic test_back_to_back;
        int   who [4];
        int   at  [4];
        int   n, e, last_who;
        logic chk_next;
        n = 0; e = 0; last_who = 0; chk_next = 1'b0;
        req0_rs = 1'b1; req0_data = 8'h35; req0_valid = 1'b1;
        req1_rs = 1'b0; req1_data = 8'h10; req1_valid = 1'b1;
        while (n < 4 && e < 140) begin
            tick(); e++;
            if (chk_next) begin
                chk_next = 1'b0;
                checks++; if (LCD_DATA !== (last_who == 0 ? 8'h35 : 8'h10)) begin errors++; $display("FAIL b2b_data edge %0d got %h want %h", e, LCD_DATA, (last_who == 0 ? 8'h35 : 8'h10)); end
                checks++; if (LCD_RS !== (last_who == 0)) begin errors++; $display("FAIL b2b_rs edge %0d got %0b want %0b", e, LCD_RS, (last_who == 0)); end
            end
            checks++; if ((req0_ready & req1_ready) !== 1'b0) begin errors++; $display("FAIL b2b_ready_overlap edge %0d got 11 want not both", e); end
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                who[n] = (req0_ready === 1'b1) ? 0 : 1;
                at[n]  = e;
                last_who = who[n];
                n++;
                chk_next = 1'b1;
                if (n == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            end
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_grant_count got %0d want 4", n); end
        tick();
        if (chk_next) begin
            checks++; if (LCD_DATA !== 8'h10) begin errors++; $display("FAIL b2b_last_data got %h want 10", LCD_DATA); end
        end
        for (int i = 0; i < n; i++) begin
            checks++; if (who[i] !== (i % 2)) begin errors++; $display("FAIL b2b_order grant %0d got req%0d want req%0d", i, who[i], i % 2); end
            if (i > 0) begin
                checks++; if ((at[i] - at[i-1]) !== 32) begin errors++; $display("FAIL b2b_spacing grant %0d got %0d want 32", i, at[i] - at[i-1]); end
            end
        end
        if (n > 0) begin
            checks++; if (at[0] !== 1) begin errors++; $display("FAIL b2b_first_latency got %0d want 1", at[0]); end
        end
        repeat (31) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %0b want 0", busy); end
        checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL b2b_idle_ready got %0b%0b want 00", req0_ready, req1_ready); end
    endtask

    task automatic test_single;
        req0_rs = 1'b1; req0_data = 8'h31; req0_valid = 1'b1;
        tick();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got %0b want 1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready got %0b want 0", req1_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_grant got %0b want 0", busy); end
        req0_valid = 1'b0;
        tick();
        observe_slot(1'b1, 8'h31, 31, "single");
    endtask

    task automatic test_long;
        req1_rs = 1'b0; req1_data = 8'h01; req1_valid = 1'b1;
        tick();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL long_req1_ready got %0b want 1", req1_ready); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL long_req0_ready got %0b want 0", req0_ready); end
        req1_valid = 1'b0;
        req0_rs = 1'b1; req0_data = 8'h39; req0_valid = 1'b1;
        tick();
        observe_slot(1'b0, 8'h01, 101, "long");
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL long_queued_ready got %0b want 1", req0_ready); end
        req0_valid = 1'b0;
        tick();
        observe_slot(1'b1, 8'h39, 31, "after_long");
    endtask

    task automatic test_init_request;
        rst = 1'b1;
        req0_rs = 1'b1; req0_data = 8'h41; req0_valid = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int e = 1; e <= 264; e++) begin
            tick();
            if (e < 264) begin
                checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL initreq_early_ready edge %0d got %0b want 0", e, req0_ready); end
            end else begin
                checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL initreq_done got %0b want 1", init_done); end
                checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL initreq_first_idle_ready got %0b want 1", req0_ready); end
            end
        end
        req0_valid = 1'b0;
        tick();
        observe_slot(1'b1, 8'h41, 31, "initreq");
    endtask

    task automatic test_reset_mid_slot;
        req0_rs = 1'b1; req0_data = 8'h48; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        repeat (10) tick();
        checks++; if (LCD_E !== 1'b1) begin errors++; $display("FAIL midrst_e_before got %0b want 1", LCD_E); end
        checks++; if (LCD_DATA !== 8'h48) begin errors++; $display("FAIL midrst_data_before got %h want 48", LCD_DATA); end
        rst = 1'b1;
        tick();
        checks++; if (LCD_E !== 1'b0) begin errors++; $display("FAIL midrst_lcd_e got %0b want 0", LCD_E); end
        checks++; if (LCD_DATA !== 8'h00) begin errors++; $display("FAIL midrst_lcd_data got %h want 00", LCD_DATA); end
        checks++; if (LCD_RS !== 1'b0) begin errors++; $display("FAIL midrst_lcd_rs got %0b want 0", LCD_RS); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done got %0b want 0", init_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
        rst = 1'b0;
        for (int e = 1; e <= 70; e++) begin
            tick();
            if (e < 70) begin
                checks++; if ((LCD_E | busy) !== 1'b0) begin errors++; $display("FAIL midrst_pwr_wait edge %0d got e=%0b busy=%0b want 0", e, LCD_E, busy); end
                checks++; if (LCD_DATA !== 8'h00) begin errors++; $display("FAIL midrst_pwr_data edge %0d got %h want 00", e, LCD_DATA); end
            end else begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_init_start_busy got %0b want 1", busy); end
                checks++; if (LCD_DATA !== 8'h38) begin errors++; $display("FAIL midrst_init_start_data got %h want 38", LCD_DATA); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
        test_reset();
        test_init();
        test_back_to_back();
        test_single();
        test_long();
        test_init_request();
        test_reset_mid_slot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
